// File: rtl/spu_op_nop_pipe.sv
// spu_op_nop_pipe: programmable-depth delay stage with clock-enable stall, clear-to-constant and hold-when-invalid.
module spu_op_nop_pipe #(
  parameter int                   LATENCY    = 1,
  parameter int                   DATA_BITS  = 8,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = 'x,
  parameter string                DEVICE     = "RTL",
  parameter string                SIMULATION = "false",
  parameter string                DEBUG      = "false"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_clear,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_data
);
  if (DEVICE == "" || SIMULATION == "" || DEBUG == "") begin : g_info
    $info("spu_op_nop_pipe: empty DEVICE/SIMULATION/DEBUG string (informational only)");
  end
  if (LATENCY < 0) begin : g_bad
    $error("spu_op_nop_pipe: LATENCY must be >= 0");
  end else if (LATENCY == 0) begin : g_comb
    $info("spu_op_nop_pipe: warning, LATENCY=0 gives a purely combinational path");
    assign m_data = s_clear ? CLEAR_DATA : s_data;
  end else if (LATENCY == 1) begin : g_one
    logic [DATA_BITS-1:0] r_stage;
    always_ff @(posedge clk or negedge reset)
      if (!reset) r_stage <= CLEAR_DATA;
      else if (cke) r_stage <= s_clear ? CLEAR_DATA : s_valid ? s_data : r_stage;
    assign m_data = r_stage;
  end else begin : g_multi
    logic [DATA_BITS-1:0] r_stage [LATENCY];
    logic [DATA_BITS-1:0] w_first;
    // only stage 1 qualifies on clear/valid; the rest is a plain shift
    assign w_first = s_clear ? CLEAR_DATA : s_valid ? s_data : r_stage[0];
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        for (int i = 0; i < LATENCY; i++) r_stage[i] <= CLEAR_DATA;
      end else if (cke) begin
        r_stage[0] <= w_first;
        for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
      end
    assign m_data = r_stage[LATENCY-1];
  end
endmodule

// File: tb/tb_spu_op_nop_pipe.sv
// tb_spu_op_nop_pipe: directed scoreboard bench over LATENCY 0..4 instances sharing one stimulus.
module tb_spu_op_nop_pipe;
  localparam logic [7:0] CLR = 8'hA5;
  typedef struct {int due; logic [7:0] v;} ent_t;
  logic clk = 0, reset = 1, cke = 1, s_clear = 0, s_valid = 0;
  logic [7:0] s_data = 0;
  logic [7:0] m0, m1, m2, m3, m4, m_sel;
  int tests = 0, fails = 0, lat = 0, cyc = 0;
  logic [7:0] cur = CLR;
  ent_t q[$];
  always #5 clk = ~clk;
  spu_op_nop_pipe #(.LATENCY(0), .DATA_BITS(8), .CLEAR_DATA(CLR)) u0 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid), .m_data(m0));
  spu_op_nop_pipe #(.LATENCY(1), .DATA_BITS(8), .CLEAR_DATA(CLR)) u1 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid), .m_data(m1));
  spu_op_nop_pipe #(.LATENCY(2), .DATA_BITS(8), .CLEAR_DATA(CLR)) u2 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid), .m_data(m2));
  spu_op_nop_pipe #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(CLR)) u3 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid), .m_data(m3));
  spu_op_nop_pipe #(.LATENCY(4), .DATA_BITS(8), .CLEAR_DATA(CLR)) u4 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid), .m_data(m4));
  always_comb m_sel = lat == 0 ? m0 : lat == 1 ? m1 : lat == 2 ? m2 : lat == 3 ? m3 : m4;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset(input int l, input string tag);
    lat = l;
    @(posedge clk);
    #2 reset = 0; s_clear = 0; s_valid = 0; cke = 1;
    #1 chk({tag, "_rst_async"}, m_sel, CLR);
    @(posedge clk);
    #1 chk({tag, "_rst_held"}, m_sel, CLR);
    #1 reset = 1;
    q.delete(); cur = CLR; cyc = 0;
  endtask
  task automatic step(input logic c, input logic v, input logic [7:0] d, input logic k, input string tag);
    s_clear = c; s_valid = v; s_data = d; cke = k;
    @(posedge clk);
    #1;
    if (k) begin
      cyc++;
      if (c) q.push_back('{due: cyc + lat - 1, v: CLR});
      else if (v) q.push_back('{due: cyc + lat - 1, v: d});
    end
    while (q.size() > 0 && q[0].due <= cyc) cur = q.pop_front().v;
    chk(tag, m_sel, cur);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    do_reset(3, "lat3");
    step(0, 1, 8'h11, 1, "lat3_a");
    step(0, 1, 8'h22, 1, "lat3_b");
    step(0, 1, 8'h33, 1, "lat3_c");
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, "lat3_drain");
    do_reset(2, "hold");
    step(0, 1, 8'h5C, 1, "hold_acc");
    for (int i = 0; i < 5; i++) step(0, 0, 8'hFF, 1, "hold_inv");
    do_reset(1, "clr");
    step(1, 1, 8'h3C, 1, "clr_prio");
    step(0, 1, 8'h3C, 1, "clr_data");
    step(1, 0, 8'h3C, 1, "clr_only");
    step(0, 0, 8'h3C, 1, "clr_hold");
    do_reset(3, "stall");
    step(0, 1, 8'h01, 1, "stall_1");
    step(0, 1, 8'h02, 1, "stall_2");
    step(0, 1, 8'h03, 1, "stall_3");
    step(0, 1, 8'h04, 0, "stall_off");
    step(0, 1, 8'h04, 0, "stall_off");
    step(0, 1, 8'h04, 1, "stall_4");
    step(0, 1, 8'h05, 1, "stall_5");
    step(0, 1, 8'h06, 1, "stall_6");
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, "stall_drain");
    do_reset(4, "mid");
    for (int i = 1; i <= 5; i++) step(0, 1, 8'h10 + 8'(i), 1, "mid_fill");
    #1 reset = 0;
    #1 chk("mid_async", m4, CLR);
    s_valid = 1; s_data = 8'h99;
    @(posedge clk);
    #1 chk("mid_held", m4, CLR);
    #1 reset = 1;
    q.delete(); cur = CLR; cyc = 0;
    for (int i = 1; i <= 4; i++) step(0, 1, 8'h20 + 8'(i), 1, "mid_new");
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, "mid_drain");
    lat = 0;
    s_clear = 0; s_valid = 0; cke = 0; s_data = 8'h77;
    #1 chk("l0_pass", m0, 8'h77);
    s_clear = 1;
    #1 chk("l0_clear", m0, CLR);
    s_clear = 0; s_data = 8'h5A; cke = 1; s_valid = 1;
    #1 chk("l0_pass2", m0, 8'h5A);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spu_op_nop_pipe.md
Name: spu_op_nop_pipe

Overview:
- Parameterised pipeline-delay ("no operation") stage for the ES1 SPU operator library.
- Every SPU arithmetic/logic operator computes its result combinationally, then instantiates this block to add its configured latency.
- Provides a programmable register depth, a clock-enable stall, a clear-to-constant, and a hold-when-invalid register.

Parameters:
- LATENCY, 1: number of register stages, ≥0. Negative values are an elaboration error. 0 is legal but issues an elaboration warning.
- DATA_BITS, 8: width of s_data and m_data.
- CLEAR_DATA, all-x (DATA_BITS wide): value loaded on clear or reset.
- DEVICE, "RTL": target device string. Informational only; no functional effect.
- SIMULATION, "false": simulation flag. No functional effect.
- DEBUG, "false": debug flag. No functional effect.

Ports:
- clk, input, 1: clock, rising-edge.
- reset, input, 1: one clock; reset is asynchronous and active-low (0 = reset asserted).
- cke, input, 1: clock enable. When 0, all state freezes.
- s_data, input, DATA_BITS: input data.
- s_clear, input, 1: clear request, aligned with s_data.
- s_valid, input, 1: s_data valid, aligned with s_data.
- m_data, output, DATA_BITS: delayed data.

Behaviour:
- Reset while reset=0, asynchronous and independent of cke: every stage register is set to CLEAR_DATA, so m_data = CLEAR_DATA. Normal operation resumes on the first rising edge after reset returns to 1.
- LATENCY=0 is purely combinational: m_data = s_clear ? CLEAR_DATA : s_data. s_valid and cke are ignored; there is no state.
- LATENCY=N≥1 uses N register stages, stage 1 through stage N, with m_data = stage N.
- Stage 1, on a rising edge with cke=1:
  - if s_clear=1: load CLEAR_DATA (clear has priority over valid);
  - else if s_valid=1: load s_data;
  - else: hold its current value.
- Stages 2..N, on a rising edge with cke=1: stage k ← stage k-1 unconditionally, a plain shift.
- Any edge with cke=0: no register changes. The pipeline stalls without losing or duplicating data.
- Latency: a value accepted at edge t (cke=1) appears on m_data after N cke-qualified edges, i.e. after edge t+N-1 when cke is held high.
- Simultaneous s_clear=1 and s_valid=1: the clear wins and CLEAR_DATA enters the pipe.
- After an accepted word followed by s_valid=0, stage 1 keeps re-issuing the last word. m_data settles to the last valid or cleared value and holds it indefinitely.
- Reset mid-operation: all in-flight data is discarded immediately, without waiting for a clock edge.
- The clear and valid qualifiers are not themselves delayed. They act only at stage 1.
- Implementation structure: generate branches for N=0, N=1 and N≥2, with the stage array sized N.

Test Plan (CLEAR_DATA=8'hA5, DATA_BITS=8 unless noted):
- Reset then latency, LATENCY=3, cke=1: assert reset=0, release, then drive s_valid=1 with s_data=8'h11,8'h22,8'h33 on consecutive edges -> m_data=8'hA5 during and after reset; 8'h11 after the 3rd edge; then 8'h22 and 8'h33 on the following edges.
- Hold on invalid, LATENCY=2: accept 8'h5C, then s_valid=0 with s_data=8'hFF for 5 cycles -> m_data becomes 8'h5C after 2 edges and stays 8'h5C; 8'hFF never appears.
- Clear priority, LATENCY=1: s_clear=1 and s_valid=1 with s_data=8'h3C -> m_data=8'hA5 after 1 edge. Next cycle s_clear=0, s_valid=1, s_data=8'h3C -> m_data=8'h3C.
- Stall, LATENCY=3: stream 8'h01..8'h06 with cke toggled low for 2 cycles mid-stream -> m_data freezes during the cke=0 cycles, then the output sequence is exactly 8'h01..8'h06 in order, with no drops or repeats.
- Async reset mid-stream, LATENCY=4: pull reset low between clock edges while the pipe holds data -> m_data=8'hA5 immediately, without waiting for an edge. After release, new data appears only after 4 edges.
- LATENCY=0: s_data=8'h77 with s_clear=0 -> m_data=8'h77 in the same cycle; s_clear=1 -> m_data=8'hA5 combinationally.
